// File: rtl/traffic_pkg.sv
// Shared definitions for the junction light sequencer: state encoding, lamp codes, default durations.
// Latency: none (definitions only).
// Backpressure: none.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_MG = 2'd0,
    ST_MY = 2'd1,
    ST_CG = 2'd2,
    ST_CY = 2'd3
  } state_t;

  // Lamp vectors are {R,Y,G}, one-hot, active-high
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int DEF_MG_TIME = 25;
  localparam int DEF_CG_TIME = 15;
  localparam int DEF_Y_TIME  = 5;

endpackage

// File: rtl/half_sec_phase.sv
// Half-second phase divider: C flips on every TICK; SEC marks the TICK that closes a whole second.
// Latency: C updates one cycle after TICK; SEC is a same-cycle strobe qualified by TICK.
// Backpressure: none; every TICK is consumed.
module half_sec_phase (
  input  logic CLK,
  input  logic RET,
  input  logic TICK,
  output logic C,
  output logic SEC
);

  // C is held directly as ~h so the blink output is a plain flop
  always_ff @(posedge CLK) begin
    if (RET)
      C <= 1'b1;
    else if (TICK)
      C <= ~C;
  end

  // A second ends on a TICK arriving while h==1, i.e. while C==0
  assign SEC = TICK & ~C;

endmodule

// File: rtl/traffic_sequencer.sv
// Main/country crossing light sequencer with remaining-time countdowns and a vehicle-sensor hold in MG.
// Latency: a TICK on cycle n shows in C, countdowns, lamps and state on cycle n+1; all outputs registered.
// Backpressure: none; TICK and CAR are sampled every cycle.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int MG_TIME = DEF_MG_TIME,
  parameter int CG_TIME = DEF_CG_TIME,
  parameter int Y_TIME  = DEF_Y_TIME
) (
  input  logic       CLK,
  input  logic       RET,
  input  logic       TICK,
  input  logic       CAR,
  output logic [4:0] MainCountdown,
  output logic [4:0] CountryCountdown,
  output logic       C,
  output logic [2:0] MainLight,
  output logic [2:0] CountryLight
);

  localparam logic [4:0] MG_T  = 5'(MG_TIME);
  localparam logic [4:0] CG_T  = 5'(CG_TIME);
  localparam logic [4:0] Y_T   = 5'(Y_TIME);
  localparam logic [4:0] MGY_T = 5'(MG_TIME + Y_TIME);
  localparam logic [4:0] CGY_T = 5'(CG_TIME + Y_TIME);

  state_t     state, state_nxt;
  logic [4:0] main_nxt, country_nxt;
  logic [2:0] main_light_nxt, country_light_nxt;
  logic [4:0] own_cnt;
  logic       sec;

  half_sec_phase u_half_sec_phase (
    .CLK  (CLK),
    .RET  (RET),
    .TICK (TICK),
    .C    (C),
    .SEC  (sec)
  );

  // Next state, countdown reload/decrement and lamp decode of the next state
  always_comb begin
    state_nxt         = state;
    main_nxt          = MainCountdown;
    country_nxt       = CountryCountdown;
    main_light_nxt    = LAMP_G;
    country_light_nxt = LAMP_R;
    // The countdown that governs the phase belongs to the road whose light is not red
    own_cnt = (state == ST_MG || state == ST_MY) ? MainCountdown : CountryCountdown;

    if (sec) begin
      if (own_cnt > 5'd1) begin
        main_nxt    = MainCountdown - 5'd1;
        country_nxt = CountryCountdown - 5'd1;
      end else begin
        case (state)
          ST_MG: begin
            if (CAR) begin
              state_nxt   = ST_MY;
              main_nxt    = Y_T;
              country_nxt = Y_T;
            end else begin
              // No vehicle waiting: rerun main green from the top
              main_nxt    = MG_T;
              country_nxt = MGY_T;
            end
          end
          ST_MY: begin
            state_nxt   = ST_CG;
            main_nxt    = CGY_T;
            country_nxt = CG_T;
          end
          ST_CG: begin
            state_nxt   = ST_CY;
            main_nxt    = Y_T;
            country_nxt = Y_T;
          end
          default: begin
            state_nxt   = ST_MG;
            main_nxt    = MG_T;
            country_nxt = MGY_T;
          end
        endcase
      end
    end

    case (state_nxt)
      ST_MG: begin
        main_light_nxt    = LAMP_G;
        country_light_nxt = LAMP_R;
      end
      ST_MY: begin
        main_light_nxt    = LAMP_Y;
        country_light_nxt = LAMP_R;
      end
      ST_CG: begin
        main_light_nxt    = LAMP_R;
        country_light_nxt = LAMP_G;
      end
      default: begin
        main_light_nxt    = LAMP_R;
        country_light_nxt = LAMP_Y;
      end
    endcase
  end

  // State, countdown and lamp registers; reset abandons any phase and restarts MG
  always_ff @(posedge CLK) begin
    if (RET) begin
      state            <= ST_MG;
      MainCountdown    <= MG_T;
      CountryCountdown <= MGY_T;
      MainLight        <= LAMP_G;
      CountryLight     <= LAMP_R;
    end else begin
      state            <= state_nxt;
      MainCountdown    <= main_nxt;
      CountryCountdown <= country_nxt;
      MainLight        <= main_light_nxt;
      CountryLight     <= country_light_nxt;
    end
  end

endmodule
